// File: rtl/datagen_pkg.sv
// Shared types and constants for the stimulus data generator sequencer.
package datagen_pkg;

  localparam int LEN_W_DEF  = 16;
  localparam int FIFO_DEPTH = 2;

  localparam logic MODE_SEQ  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/datagen_seq_fifo.sv
// Two-entry output FIFO with flush. Entry 0 is always the head, so head data
// comes straight from a register.
module datagen_seq_fifo
  import datagen_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        count_o,
  output logic [1:0]        count_nxt_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              vld_q;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = din_i;
          else               e1_d = din_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop keeps the count; the new byte lands
          // behind whatever remains.
          if (cnt_q == 2'd1) begin
            e0_d = din_i;
          end else begin
            e0_d = e1_q;
            e1_d = din_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
      vld_q <= 1'b0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
      vld_q <= (cnt_d != 2'd0);
    end
  end

  assign head_o      = e0_q;
  assign count_o     = cnt_q;
  assign count_nxt_o = cnt_d;
  assign valid_o     = vld_q;

endmodule

// File: rtl/datagen_seq.sv
// Burst sequencer: programs generator mode and meters gen_en so exactly N bytes
// reach the downstream stream. Optional inter-issue gap: DATAGEN_SEQ_GAP_EN.
module datagen_seq
  import datagen_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef DATAGEN_SEQ_GAP_EN
  input  logic [7:0]       cfg_gap,
`endif
  input  logic             cfg_start,
  input  logic             cfg_mode,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_abort,
  output logic             gen_mode,
  output logic             gen_en,
  input  logic [7:0]       gen_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] beat_cnt
);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic             infl_q, infl_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_q, last_d;

  logic             fifo_vld, pop, push, gap_ok;
  logic [1:0]       fifo_cnt, fifo_cnt_nxt;
  logic [7:0]       fifo_head;
  logic [2:0]       occ_eff;
  logic [LEN_W:0]   beat_inc;

  assign pop  = fifo_vld & m_ready;
  assign push = infl_q & ~cfg_abort;

  datagen_seq_fifo #(.DATA_W(8)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush_i    (cfg_abort),
    .push_i     (push),
    .pop_i      (pop),
    .din_i      (gen_data),
    .head_o     (fifo_head),
    .count_o    (fifo_cnt),
    .count_nxt_o(fifo_cnt_nxt),
    .valid_o    (fifo_vld)
  );

`ifdef DATAGEN_SEQ_GAP_EN
  logic [7:0] gap_len_q, gap_len_d, gap_cnt_q, gap_cnt_d;

  assign gap_ok = (gap_cnt_q == 8'd0);

  always_comb begin
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    if (gap_cnt_q != 8'd0) gap_cnt_d = gap_cnt_q - 8'd1;
    if (gen_en)            gap_cnt_d = gap_len_q;
    if (cfg_abort) begin
      gap_cnt_d = 8'd0;
    end else if (state_q == IDLE && cfg_start) begin
      gap_len_d = cfg_gap;
      gap_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_len_q <= 8'd0;
      gap_cnt_q <= 8'd0;
    end else begin
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end
`else
  assign gap_ok = 1'b1;
`endif

  always_comb begin
    // Bytes already committed (buffered or in flight) after this cycle's pop.
    occ_eff = {1'b0, fifo_cnt} + {2'b00, infl_q} - {2'b00, pop};
    gen_en  = (state_q == RUN) && (issued_q < len_q) &&
              (occ_eff < 3'(FIFO_DEPTH)) && !cfg_abort && gap_ok;

    state_d  = state_q;
    mode_d   = mode_q;
    len_d    = len_q;
    issued_d = gen_en ? issued_q + 1'b1 : issued_q;
    beat_d   = (pop && beat_q < len_q) ? beat_q + 1'b1 : beat_q;
    infl_d   = gen_en;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_len != '0) begin
            state_d  = RUN;
            mode_d   = cfg_mode;
            len_d    = cfg_len;
            issued_d = '0;
            beat_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issued_d == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_cnt == 2'd0 && !infl_q && beat_q == len_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    if (cfg_abort) begin
      state_d  = IDLE;
      mode_d   = mode_q;
      len_d    = len_q;
      issued_d = issued_q;
      beat_d   = beat_q;
      infl_d   = 1'b0;
      done_d   = 1'b0;
    end

    busy_d   = (state_d != IDLE);
    beat_inc = {1'b0, beat_d} + {{LEN_W{1'b0}}, 1'b1};
    last_d   = (fifo_cnt_nxt != 2'd0) && (beat_inc == {1'b0, len_d});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mode_q   <= MODE_SEQ;
      len_q    <= '0;
      issued_q <= '0;
      beat_q   <= '0;
      infl_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      beat_q   <= beat_d;
      infl_q   <= infl_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      last_q   <= last_d;
    end
  end

  assign gen_mode = mode_q;
  assign m_valid  = fifo_vld;
  assign m_data   = fifo_head;
  assign m_last   = last_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign beat_cnt = beat_q;

endmodule

// File: doc/datagen_seq.md
# datagen_seq

Burst sequencer for the stimulus data generator. It programs the generator's mode and meters its advance so that exactly N bytes, sequential or LFSR, reach the downstream accelerator input on a valid/ready stream with back-pressure. Sits between the control registers and the generator/accelerator datapath. It is the only block that drives the generator's mode and enable.

## Interface
- `LEN_W`, 16: width of the burst-length field and the beat counter.
- `clk` input 1: single clock, all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `cfg_start` input 1: one-cycle start request; sampled only in IDLE.
- `cfg_mode` input 1: 0 = sequential, 1 = LFSR; latched at start.
- `cfg_len` input LEN_W: burst length in bytes; latched at start.
- `cfg_abort` input 1: terminate the current burst, any state.
- `gen_mode` output 1: mode to the generator; held stable for the whole burst.
- `gen_en` output 1: generator advances one value on a cycle where this is high.
- `gen_data` input 8: generator output, valid the cycle after `gen_en`.
- `m_valid` output 1, `m_ready` input 1, `m_data` output 8, `m_last` output 1: downstream stream.
- `busy` output 1: high outside IDLE.
- `done` output 1: one-cycle pulse when a burst completes normally.
- `beat_cnt` output LEN_W: bytes accepted downstream in the current or last burst.

## Operation
- FSM states:
  - IDLE → RUN: on `cfg_start` with `cfg_len`≠0. Latches mode and length, clears issue count and `beat_cnt`.
  - `cfg_start` with `cfg_len`=0: `done` pulses the next cycle, FSM stays IDLE.
  - RUN → DRAIN: when issued count equals length.
  - DRAIN → DONE: when buffer empty, nothing in flight, and last beat accepted.
  - DONE → IDLE: after one cycle; `done`=1 during DONE.
- Buffer: 2-entry output FIFO holds generator bytes.
- In-flight flag: set by `gen_en`, cleared when `gen_data` is captured the next cycle.
- `gen_en` rule: RUN and issued<len and (occupancy + inflight − pop) < 2, where pop = `m_valid`&`m_ready` this cycle.
- The buffer never overflows and no generator value is lost.
- `m_data` is the FIFO head; `m_valid` = FIFO non-empty.
- `m_last` = 1 on the head beat when `beat_cnt`+1 = len.
- `beat_cnt` increments on each accepted beat and saturates at len.
- `cfg_start` while busy: ignored, no state change.
- `cfg_abort`:
  - Next cycle: FIFO flushed, in-flight byte discarded, FSM → IDLE.
  - No `done` pulse; `beat_cnt` holds its value.
  - Abort takes priority over a simultaneous start or completion.
- `gen_mode` holds the latched mode in every state, including IDLE after a burst.
- Counter arithmetic is unsigned LEN_W; length 2^LEN_W−1 is legal and must not wrap.
- Reset values:
  - State IDLE; `gen_mode`=0; `gen_en`=0.
  - `m_valid`=0, `m_data`=0, `m_last`=0.
  - `busy`=0, `done`=0, `beat_cnt`=0.
  - FIFO empty, inflight=0.
- Reset mid-burst returns to these values immediately.

## Timing
- `cfg_start` high in cycle 0 → RUN and first `gen_en` in cycle 1 → `gen_data` captured end of cycle 2 → `m_valid` first high in cycle 3.
- `m_ready` held high: one beat per cycle, no bubbles after the first.
- N-byte burst: last beat in cycle N+2, `done` in cycle N+4.
- `m_ready` low: at most 2 bytes buffered; `gen_en` stalls within one cycle.
- `m_valid`/`m_data` stay stable while `m_valid`&!`m_ready`.
- `done`, `busy` and all stream outputs are registered.

## Configuration
- `DATAGEN_SEQ_GAP_EN` defined:
  - Adds input port `cfg_gap`, 8 bits, latched at start.
  - After each `gen_en`, `gen_en` is held low for `cfg_gap` cycles; gap counter is reset by abort.
  - Gap 0 matches the undefined case exactly.
- Undefined: no `cfg_gap` port and no gap counter; `gen_en` follows the rule above only.

## Structure
- Shared package `datagen_pkg`: FSM state enum (IDLE, RUN, DRAIN, DONE), mode constants (MODE_SEQ=0, MODE_LFSR=1), default `LEN_W`.
- One sub-module, `datagen_seq_fifo`: 2-entry FIFO with flush, push, pop, count, head data.

## Test plan
- `cfg_mode`=0, `cfg_len`=4, `m_ready`=1, generator fresh from reset → `m_data` 00,01,02,03 in cycles 3–6; `m_last` only on 03; `done` in cycle 8; `beat_cnt`=4.
- `cfg_mode`=1, `cfg_len`=3, generator seed 01 → bytes 01,02,04; `gen_mode`=1 throughout; exactly 3 `gen_en` cycles.
- `cfg_len`=8, `m_ready` toggled 1,0,0,1 repeating → no lost or duplicated byte; `m_data` stable while stalled; at most 2 buffered; total 8 beats.
- `cfg_len`=0 start → no `gen_en`, no `m_valid`, `done` pulse next cycle; `cfg_start` during RUN → ignored, burst unaffected.
- `cfg_abort` after 2 of 6 beats accepted with a byte in flight → IDLE next cycle, `m_valid`=0, no `done`, `beat_cnt`=2.
- `reset_n` low mid-burst → all outputs at reset values asynchronously; new `cfg_len`=2 burst after release completes normally.
- With `DATAGEN_SEQ_GAP_EN` and `cfg_gap`=2 → `gen_en` exactly every 3rd cycle.
